bit_scan_ctrl: RTL and testbench

Sequencer that captures a `[MSB:LSB]` vector and streams selected bits out one per beat by walking a signed bit-select index from a start position, with a fixed step of +1 or -1. Packed-range semantics match the language rules for both ascending and descending ranges, including negative bounds, and out-of-range selects are handled explicitly. It sits in front of bit-select datapaths to sequence serial bit extraction under valid/ready flow control.

---
 rtl/bit_scan_pkg.sv | 32 +++
 rtl/bit_scan_index.sv | 27 ++
 rtl/bit_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_bit_scan_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg: FSM state type and range helpers shared by the bit scanner.
// Config macro: BIT_SCAN_OOB_FLAG_EN (consumed in bit_scan_ctrl).
package bit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Signed membership test valid for both range orientations.
  function automatic logic in_range(
    input int sel,
    input int msb,
    input int lsb
  );
    if (msb >= lsb) return (sel <= msb) && (sel >= lsb);
    return (sel >= msb) && (sel <= lsb);
  endfunction

  function automatic int span(
    input int msb,
    input int lsb
  );
    return (msb >= lsb) ? msb - lsb + 1 : lsb - msb + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_scan_index.sv
// bit_scan_index: range check and right-end bit offset for a signed index.
// Ports: sel (index) -> oob (outside [MSB:LSB]), offset (from right end).
module bit_scan_index
  import bit_scan_pkg::*;
#(
  parameter int MSB  = 4,
  parameter int LSB  = 0,
  parameter int SELW = 5,
  parameter int OFFW = 3
) (
  input  logic signed [SELW-1:0] sel,
  output logic                   oob,
  output logic        [OFFW-1:0] offset
);

  int sel_int;
  int off_int;

  always_comb begin
    sel_int = int'(sel);
    oob     = !in_range(sel_int, MSB, LSB);
    // The right end of the vector is always LSB, whichever way it counts.
    off_int = (MSB >= LSB) ? sel_int - LSB : LSB - sel_int;
    offset  = OFFW'(off_int);
  end

endmodule

// File: rtl/bit_scan_ctrl.sv
// bit_scan_ctrl: captures a [MSB:LSB] vector and streams bit-selects out.
// Ports: clk, rst, start/data_in/first_sel/count/dir in; busy, out_valid/
// out_ready, out_bit, out_sel, out_oob, done. Macro: BIT_SCAN_OOB_FLAG_EN.
module bit_scan_ctrl
  import bit_scan_pkg::*;
#(
  parameter int MSB  = 4,
  parameter int LSB  = 0,
  parameter int SELW = 5,
  parameter int CNTW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MSB:LSB]         data_in,
  input  logic signed [SELW-1:0] first_sel,
  input  logic [CNTW-1:0]        count,
  input  logic                   dir,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_bit,
  output logic signed [SELW-1:0] out_sel,
  output logic                   out_oob,
  output logic                   done
);

  localparam int NBITS = span(MSB, LSB);
  localparam int OFFW  = idx_w(NBITS);
  localparam int FLATW = 1 << OFFW;

  state_e                 state_q;
  logic [MSB:LSB]         data_q;
  logic signed [SELW-1:0] sel_q;
  logic signed [SELW-1:0] sel_d;
  logic [CNTW-1:0]        rem_q;
  logic                   dir_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   hs;

  logic                   oob;
  logic [OFFW-1:0]        offset;
  logic [FLATW-1:0]       flat;
  logic                   bit_raw;

  bit_scan_index #(
    .MSB (MSB),
    .LSB (LSB),
    .SELW(SELW),
    .OFFW(OFFW)
  ) u_index (
    .sel   (sel_q),
    .oob   (oob),
    .offset(offset)
  );

  assign hs    = busy_q & out_ready;
  // Two's-complement wrap is the natural SELW-bit overflow.
  assign sel_d = dir_q ? sel_q + 1'b1 : sel_q - 1'b1;

  // Packed copy puts the LSB end at bit 0 for either orientation.
  always_comb begin
    flat            = '0;
    flat[NBITS-1:0] = data_q;
  end

`ifdef BIT_SCAN_OOB_FLAG_EN
  assign bit_raw = oob ? 1'b0 : flat[offset];
  assign out_oob = busy_q & oob;
`else
  assign bit_raw = oob ? 1'bx : flat[offset];
  assign out_oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            data_q <= data_in;
            sel_q  <= first_sel;
            rem_q  <= count;
            dir_q  <= dir;
            if (count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            sel_q <= sel_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == CNTW'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = busy_q;
  assign done      = done_q;
  assign out_sel   = sel_q;
  assign out_bit   = busy_q & bit_raw;

endmodule

// File: tb/tb_bit_scan_ctrl.sv
// tb_bit_scan_ctrl: table-driven scans with a beat scoreboard, plus stall,
// mid-scan reset and ascending-range sequences.
module tb_bit_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start0, dir0, ready0;
  logic [4:-2]       din0;
  logic signed [4:0] fsel0;
  logic [3:0]        cnt0;
  logic              busy0, valid0, bit0, oob0, done0;
  logic signed [4:0] sel0;

  logic              start1, dir1, ready1;
  logic [0:6]        din1;
  logic signed [4:0] fsel1;
  logic [3:0]        cnt1;
  logic              busy1, valid1, bit1, oob1, done1;
  logic signed [4:0] sel1;

  bit_scan_ctrl #(.MSB(4), .LSB(-2), .SELW(5), .CNTW(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .data_in(din0),
    .first_sel(fsel0), .count(cnt0), .dir(dir0), .busy(busy0),
    .out_valid(valid0), .out_ready(ready0), .out_bit(bit0),
    .out_sel(sel0), .out_oob(oob0), .done(done0)
  );

  bit_scan_ctrl #(.MSB(0), .LSB(6), .SELW(5), .CNTW(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(din1),
    .first_sel(fsel1), .count(cnt1), .dir(dir1), .busy(busy1),
    .out_valid(valid1), .out_ready(ready1), .out_bit(bit1),
    .out_sel(sel1), .out_oob(oob1), .done(done1)
  );

  typedef struct {
    logic [6:0]        data;
    logic signed [4:0] first;
    logic [3:0]        cnt;
    logic              dir;
    logic [15:0]       eb;
    logic [15:0]       eo;
  } vec_t;

  typedef struct packed {
    logic       b;
    logic [4:0] s;
    logic       o;
  } beat_t;

  vec_t  tv[5];
  beat_t q[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: one expected beat per handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid0 === 1'b1 && ready0 === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL extra_beat: sel %0d with empty queue", sel0);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("beat_sel", {27'b0, sel0}, {27'b0, e.s});
`ifdef BIT_SCAN_OOB_FLAG_EN
        chk("beat_oob", {31'b0, oob0}, {31'b0, e.o});
        chk("beat_bit", {31'b0, bit0}, e.o ? 32'd0 : {31'b0, e.b});
`else
        chk("beat_oob", {31'b0, oob0}, 32'd0);
        if (!e.o) chk("beat_bit", {31'b0, bit0}, {31'b0, e.b});
`endif
      end
    end
  end

  task automatic push_beats(input vec_t v);
    logic signed [4:0] s;
    beat_t e;
    s = v.first;
    for (int i = 0; i < int'(v.cnt); i++) begin
      e.b = v.eb[i];
      e.o = v.eo[i];
      e.s = s;
      q.push_back(e);
      s = v.dir ? s + 5'sd1 : s - 5'sd1;
    end
  endtask

  task automatic drive_start(input vec_t v);
    @(posedge clk); #1;
    start0 = 1'b1;
    din0   = v.data;
    fsel0  = v.first;
    cnt0   = v.cnt;
    dir0   = v.dir;
    ready0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic run_scan(input vec_t v, input int sb, input int sl,
                          input bit poke);
    int                expd;
    bit                seen;
    logic              pb;
    logic signed [4:0] ps;
    expd = int'(v.cnt) + 1 + ((sb > 0 && v.cnt != 0) ? sl : 0);
    push_beats(v);
    drive_start(v);
    seen = 1'b0;
    ps   = '0;
    pb   = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      ready0 = !(sb > 0 && c >= sb && c < sb + sl);
      if (poke) begin
        start0 = (c == 2);
        din0   = (c == 2) ? ~v.data : v.data;
      end
      @(negedge clk);
      if (sb > 0 && c > sb && c <= sb + sl) begin
        chk("hold_sel", {27'b0, sel0}, {27'b0, ps});
        chk("hold_bit", {31'b0, bit0}, {31'b0, pb});
      end
      ps = sel0;
      pb = bit0;
      if (done0 === 1'b1) begin
        seen = 1'b1;
        chk("done_cycle", c, expd);
        chk("beats_left", q.size(), 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: no done within 60 cycles");
      q.delete();
    end
    ready0 = 1'b1;
    start0 = 1'b0;
  endtask

  initial begin
    tv[0] = '{7'b1011001, -5'sd2, 4'd7, 1'b1, 16'b1011001, 16'b0};
    tv[1] = '{7'b0110101, 5'sd3, 4'd4, 1'b1, 16'b0001, 16'b1100};
    tv[2] = '{7'b1111111, 5'sd15, 4'd2, 1'b1, 16'b0, 16'b11};
    tv[3] = '{7'b1110010, 5'sd1, 4'd5, 1'b0, 16'b00100, 16'b10000};
    tv[4] = '{7'b0101010, 5'sd0, 4'd0, 1'b1, 16'b0, 16'b0};

    rst = 1'b1;
    start0 = 1'b0; dir0 = 1'b0; ready0 = 1'b1;
    din0 = '0; fsel0 = '0; cnt0 = '0;
    start1 = 1'b0; dir1 = 1'b0; ready1 = 1'b1;
    din1 = '0; fsel1 = '0; cnt1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    chk("rst_valid", {31'b0, valid0}, 32'd0);
    chk("rst_bit", {31'b0, bit0}, 32'd0);
    chk("rst_oob", {31'b0, oob0}, 32'd0);
    chk("rst_done", {31'b0, done0}, 32'd0);
    chk("rst_sel", {27'b0, sel0}, 32'd0);
    chk("rst_valid1", {31'b0, valid1}, 32'd0);

    for (int i = 0; i < 5; i++) run_scan(tv[i], 0, 0, 1'b0);

    // Ready low for 3 cycles from beat 3, plus a start poke mid-run.
    run_scan(tv[0], 3, 3, 1'b1);

    // Reset during beat 2 of 5.
    push_beats(tv[3]);
    drive_start(tv[3]);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy0}, 32'd0);
    chk("abort_valid", {31'b0, valid0}, 32'd0);
    chk("abort_bit", {31'b0, bit0}, 32'd0);
    chk("abort_oob", {31'b0, oob0}, 32'd0);
    chk("abort_done", {31'b0, done0}, 32'd0);
    chk("abort_sel", {27'b0, sel0}, 32'd0);
    rst = 1'b0;
    q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, done0}, 32'd0);
    end
    run_scan(tv[0], 0, 0, 1'b0);

    // Ascending range [0:6].
    @(posedge clk); #1;
    start1 = 1'b1;
    din1   = 7'b1100000;
    fsel1  = 5'sd0;
    cnt1   = 4'd3;
    dir1   = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      logic [2:0] eb1;
      eb1 = 3'b011;
      @(negedge clk);
      chk("asc_valid", {31'b0, valid1}, 32'd1);
      chk("asc_sel", {27'b0, sel1}, c);
      chk("asc_bit", {31'b0, bit1}, {31'b0, eb1[c]});
      chk("asc_oob", {31'b0, oob1}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("asc_done", {31'b0, done1}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
